cache_controller: RTL

- 2-way set-associative, write-through, no-write-allocate data cache between the MEM stage and the SRAM controller.
- Read hits return in the same cycle with no SRAM access.
- Read misses fill a 2-word line using two back-to-back SRAM reads; all writes are forwarded to SRAM.
- The MEM stage sees a single `ready` for freezing the pipeline; the SRAM side uses the controller's enable/ready handshake.

---
 rtl/cache_controller_if.sv | 52 +++++
 rtl/cache_controller.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/cache_controller_if.sv
// Bundles the MEM-stage request port and the SRAM-controller port of the data cache.
interface cache_controller_if #(
    parameter int unsigned WORD_LEN = 32
);
    // MEM-stage side
    logic                read_enable;
    logic                write_enable;
    logic [31:0]         address;
    logic [WORD_LEN-1:0] write_data;
    logic [WORD_LEN-1:0] read_data;
    logic                ready;

    // SRAM-controller side
    logic                sram_read_enable;
    logic                sram_write_enable;
    logic [31:0]         sram_address;
    logic [WORD_LEN-1:0] sram_write_data;
    logic [WORD_LEN-1:0] sram_read_data;
    logic                sram_ready;

    // Cache controller view
    modport slave (
        input  read_enable,
        input  write_enable,
        input  address,
        input  write_data,
        output read_data,
        output ready,
        output sram_read_enable,
        output sram_write_enable,
        output sram_address,
        output sram_write_data,
        input  sram_read_data,
        input  sram_ready
    );

    // Requester / SRAM-model view
    modport master (
        output read_enable,
        output write_enable,
        output address,
        output write_data,
        input  read_data,
        input  ready,
        input  sram_read_enable,
        input  sram_write_enable,
        input  sram_address,
        input  sram_write_data,
        output sram_read_data,
        output sram_ready
    );
endinterface

// File: rtl/cache_controller.sv
// 2-way set-associative, write-through, no-write-allocate data cache with 2-word lines.
// Read hits complete in the IDLE cycle; misses fill the line with two SRAM reads.
module cache_controller #(
    parameter int unsigned SETS      = 64,
    parameter int unsigned TAG_WIDTH = 10,
    parameter int unsigned WORD_LEN  = 32
) (
    input logic               clk,
    input logic               rst,
    cache_controller_if.slave bus
);
    localparam int unsigned IdxW  = $clog2(SETS);
    localparam int unsigned IdxLo = 3;
    localparam int unsigned IdxHi = IdxLo + IdxW - 1;
    localparam int unsigned TagLo = IdxHi + 1;
    localparam int unsigned TagHi = TagLo + TAG_WIDTH - 1;

    typedef enum logic [1:0] {
        StIdle,
        StFill0,
        StFill1,
        StWrite
    } state_e;

    state_e              state_q;
    logic [31:2]         addr_q;
    logic [WORD_LEN-1:0] wdata_q;
    logic [WORD_LEN-1:0] buf0_q;
    logic                sram_re_q;
    logic                sram_we_q;
    logic [31:0]         sram_addr_q;

    // Cache storage; valid and LRU are the only bits that need a reset value
    logic [SETS-1:0]      valid_q [2];
    logic [SETS-1:0]      lru_q;
    logic [TAG_WIDTH-1:0] tag_q   [2][SETS];
    logic [WORD_LEN-1:0]  data_q  [2][SETS][2];

    logic [IdxW-1:0]      lk_idx;
    logic [TAG_WIDTH-1:0] lk_tag;
    logic                 lk_word;
    logic                 hit0;
    logic                 hit1;
    logic                 hit;
    logic                 hit_way;
    logic                 victim;
    logic [WORD_LEN-1:0]  hit_word;
    logic                 rd_req;
    logic                 wr_req;
    logic                 rd_hit;
    logic                 fill_done;
    logic                 write_done;

    // Lookup uses the live address in IDLE and the latched one while a transaction is open,
    // so a WRITE checks the tags as they stand at its completion.
    always_comb begin
        if (state_q == StIdle) begin
            lk_idx  = bus.address[IdxHi:IdxLo];
            lk_tag  = bus.address[TagHi:TagLo];
            lk_word = bus.address[2];
        end else begin
            lk_idx  = addr_q[IdxHi:IdxLo];
            lk_tag  = addr_q[TagHi:TagLo];
            lk_word = addr_q[2];
        end
    end

    // Tag compare, hit way selection and request decode
    always_comb begin
        hit0       = valid_q[0][lk_idx] && (tag_q[0][lk_idx] == lk_tag);
        hit1       = valid_q[1][lk_idx] && (tag_q[1][lk_idx] == lk_tag);
        hit        = hit0 || hit1;
        hit_way    = hit1;
        victim     = lru_q[lk_idx];
        hit_word   = data_q[hit_way][lk_idx][lk_word];
        rd_req     = (state_q == StIdle) && bus.read_enable;
        wr_req     = (state_q == StIdle) && !bus.read_enable && bus.write_enable;
        rd_hit     = rd_req && hit;
        fill_done  = (state_q == StFill1) && bus.sram_ready;
        write_done = (state_q == StWrite) && bus.sram_ready;
    end

    // MEM-side handshake: ready drops only for a miss or write until its SRAM completion
    always_comb begin
        bus.ready     = 1'b0;
        bus.read_data = '0;
        if (rst) begin
            bus.ready = 1'b1;
        end else begin
            unique case (state_q)
                StIdle:  bus.ready = !(rd_req && !hit) && !wr_req;
                StFill1: bus.ready = bus.sram_ready;
                StWrite: bus.ready = bus.sram_ready;
                default: bus.ready = 1'b0;
            endcase
            if (rd_hit) begin
                bus.read_data = hit_word;
            end else if (fill_done) begin
                bus.read_data = addr_q[2] ? bus.sram_read_data : buf0_q;
            end
        end
    end

    // SRAM outputs come straight from registers so they never glitch on sram_ready
    always_comb begin
        bus.sram_read_enable  = sram_re_q;
        bus.sram_write_enable = sram_we_q;
        bus.sram_address      = sram_addr_q;
        bus.sram_write_data   = wdata_q;
    end

    // Controller FSM with registered SRAM request outputs and request latches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            wdata_q     <= '0;
            buf0_q      <= '0;
            sram_re_q   <= 1'b0;
            sram_we_q   <= 1'b0;
            sram_addr_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.read_enable && !hit) begin
                        state_q     <= StFill0;
                        addr_q      <= bus.address[31:2];
                        sram_re_q   <= 1'b1;
                        sram_addr_q <= {bus.address[31:3], 3'b000};
                    end else if (!bus.read_enable && bus.write_enable) begin
                        state_q     <= StWrite;
                        addr_q      <= bus.address[31:2];
                        wdata_q     <= bus.write_data;
                        sram_we_q   <= 1'b1;
                        sram_addr_q <= bus.address;
                    end
                end
                StFill0: begin
                    if (bus.sram_ready) begin
                        state_q     <= StFill1;
                        buf0_q      <= bus.sram_read_data;
                        sram_addr_q <= {addr_q[31:3], 3'b100};
                    end
                end
                StFill1: begin
                    if (bus.sram_ready) begin
                        state_q     <= StIdle;
                        buf0_q      <= '0;
                        sram_re_q   <= 1'b0;
                        sram_addr_q <= '0;
                    end
                end
                StWrite: begin
                    if (bus.sram_ready) begin
                        state_q     <= StIdle;
                        wdata_q     <= '0;
                        sram_we_q   <= 1'b0;
                        sram_addr_q <= '0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Valid and LRU bookkeeping; LRU always points away from the most recently used way
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q[0] <= '0;
            valid_q[1] <= '0;
            lru_q      <= '0;
        end else if (fill_done) begin
            valid_q[victim][lk_idx] <= 1'b1;
            lru_q[lk_idx]           <= ~victim;
        end else if (rd_hit || (write_done && hit)) begin
            lru_q[lk_idx] <= ~hit_way;
        end
    end

    // Tag and data arrays: line install on fill, word update on a write hit
    always_ff @(posedge clk) begin
        if (fill_done) begin
            tag_q[victim][lk_idx]     <= lk_tag;
            data_q[victim][lk_idx][0] <= buf0_q;
            data_q[victim][lk_idx][1] <= bus.sram_read_data;
        end else if (write_done && hit) begin
            data_q[hit_way][lk_idx][addr_q[2]] <= wdata_q;
        end
    end
endmodule
